// File: rtl/mem_wif_burst_reader.sv
// Block-read initiator for the SDRAM bridge strobe/cycle interface: one command becomes
// sequential single-word reads, buffered in a show-ahead FIFO and streamed out with a last flag.
module mem_wif_burst_reader #(
  parameter int          FIFO_DEPTH   = 8,
  parameter int          LEN_W        = 16,
  parameter logic [31:0] ADDR_STEP    = 32'd1,
  parameter int          TIMEOUT      = 1023,
  parameter logic        WE_WRITE_LVL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err_timeout,
  output logic             mem_stb_i,
  output logic             mem_we_i,
  output logic             mem_sel_i,
  output logic [31:0]      mem_addr_i,
  output logic [15:0]      mem_dat_i,
  input  logic             mem_stb_o,
  input  logic             mem_cyc_o,
  input  logic [15:0]      mem_dat_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]      DEPTH_C  = FIFO_DEPTH[AW:0];
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REQ, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             stb_q, stb_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [16:0]      fifo_mem_q [FIFO_DEPTH];
  logic             push, pop, flush;
  logic [16:0]      head;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    err_d    = err_q;
    stb_d    = stb_q;
    tmo_d    = tmo_q;
    push     = 1'b0;
    flush    = 1'b0;
    pop      = (count_q != '0) && out_ready;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          err_d  = 1'b0;
          if (cmd_len != '0) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Reserving a slot before issuing guarantees the eventual push always fits.
        if (count_q < DEPTH_C) begin
          state_d = ST_REQ;
          stb_d   = 1'b1;
          tmo_d   = '0;
        end
      end
      ST_REQ: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TMO_LAST) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (mem_stb_o) begin
          stb_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // A completion in the final timeout cycle still counts as a good read.
        if (!mem_cyc_o) begin
          push    = 1'b1;
          addr_d  = addr_q + ADDR_STEP;
          rem_d   = rem_q - LEN_ONE;
          state_d = (rem_q == LEN_ONE) ? ST_IDLE : ST_HOLD;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          flush   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      stb_q    <= 1'b0;
      tmo_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      stb_q    <= stb_d;
      tmo_q    <= tmo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {rem_q == LEN_ONE, mem_dat_o};
  end

  assign head        = fifo_mem_q[rd_ptr_q];
  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? head[15:0] : 16'h0000;
  assign out_last    = out_valid & head[16];
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;
  assign mem_stb_i   = stb_q;
  assign mem_we_i    = ~WE_WRITE_LVL;
  assign mem_sel_i   = 1'b1;
  assign mem_addr_i  = addr_q;
  assign mem_dat_i   = 16'h0000;

endmodule

// File: tb/tb_mem_wif_burst_reader.sv
// Directed bench for mem_wif_burst_reader: behavioural bridge model plus a scoreboard of
// expected output words, compared as the DUT pops them.
module tb_mem_wif_burst_reader;
  localparam int LW  = 16;
  localparam int TMO = 64;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          err_timeout;
  logic          mem_stb_i;
  logic          mem_we_i;
  logic          mem_sel_i;
  logic [31:0]   mem_addr_i;
  logic [15:0]   mem_dat_i;
  logic          mem_stb_o = 1'b0;
  logic          mem_cyc_o = 1'b0;
  logic [15:0]   mem_dat_o = '0;

  int compared = 0;
  int mismatched = 0;

  logic [16:0] sb [$];
  logic [31:0] addr_log [$];
  int  reads_issued = 0;
  int  acc_dly = 1;
  int  cmp_dly = 1;
  bit  hang_en = 1'b0;
  int  hang_limit = 0;

  mem_wif_burst_reader #(
    .FIFO_DEPTH(8), .LEN_W(LW), .ADDR_STEP(32'd1), .TIMEOUT(TMO), .WE_WRITE_LVL(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_timeout(err_timeout),
    .mem_stb_i(mem_stb_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_dat_i(mem_dat_i),
    .mem_stb_o(mem_stb_o), .mem_cyc_o(mem_cyc_o), .mem_dat_o(mem_dat_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] fdata(input logic [31:0] a);
    return a[15:0] + a[31:16] + 16'h1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bridge model: accept after acc_dly cycles, complete cmp_dly cycles later.
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk_i);
      if (mem_stb_i && !rst_i) begin
        for (int k = 1; k < acc_dly; k++) @(negedge clk_i);
        if (mem_stb_i && !rst_i) begin
          a = mem_addr_i;
          reads_issued++;
          addr_log.push_back(a);
          mem_stb_o = 1'b1;
          mem_cyc_o = 1'b1;
          @(negedge clk_i);
          mem_stb_o = 1'b0;
          if (hang_en && reads_issued > hang_limit) begin
            while (hang_en) @(negedge clk_i);
          end else begin
            for (int k = 1; k < cmp_dly; k++) @(negedge clk_i);
          end
          mem_dat_o = fdata(a);
          mem_cyc_o = 1'b0;
        end
      end
    end
  end

  // Output monitor: sample mid-phase, compare the word about to be popped.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word_sb_size", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e[15:0]);
          chk("out_last", out_last, e[16]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send(input logic [31:0] a, input int len, input bit expect_out);
    logic [31:0] wa;
    cmd_addr  = a;
    cmd_len   = len[LW-1:0];
    cmd_valid = 1'b1;
    if (expect_out) begin
      for (int i = 0; i < len; i++) begin
        wa = a + 32'(i);
        sb.push_back({(i == len - 1), fdata(wa)});
      end
    end
    chk("cmd_ready_at_send", cmd_ready, 1);
    @(negedge clk_i);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, (busy || sb.size() != 0), 0);
  endtask

  initial begin
    int r0;
    int n;
    tick(3);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_stb_i", mem_stb_i, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_mem_we_i", mem_we_i, 1);
    chk("rst_mem_sel_i", mem_sel_i, 1);
    chk("rst_mem_dat_i", mem_dat_i, 0);
    chk("rst_mem_addr_i", mem_addr_i, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    rst_i = 1'b0;
    tick(2);

    // Basic 4-word burst with slow bridge.
    acc_dly = 3; cmp_dly = 5; out_ready = 1'b1;
    addr_log.delete();
    send(32'h100, 4, 1'b1);
    wait_done(300, "t1_done");
    chk("t1_nreads", addr_log.size(), 4);
    for (int i = 0; i < addr_log.size(); i++) chk("t1_addr", addr_log[i], 32'h100 + 32'(i));

    // Back-pressure: FIFO fills to 8, then drains.
    acc_dly = 1; cmp_dly = 1; out_ready = 1'b0;
    r0 = reads_issued;
    send(32'h1000, 12, 1'b1);
    tick(150);
    chk("t2_reads_full", reads_issued - r0, 8);
    chk("t2_busy", busy, 1);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_stb_idle", mem_stb_i, 0);
    out_ready = 1'b1;
    wait_done(400, "t2_done");
    chk("t2_reads_total", reads_issued - r0, 12);

    // Zero-length command.
    r0 = reads_issued;
    send(32'h2000, 0, 1'b0);
    chk("t3_cmd_ready", cmd_ready, 1);
    chk("t3_busy", busy, 0);
    tick(6);
    chk("t3_no_reads", reads_issued - r0, 0);
    chk("t3_out_valid", out_valid, 0);

    // Address wrap.
    addr_log.delete();
    send(32'hFFFF_FFFF, 2, 1'b1);
    wait_done(200, "t4_done");
    chk("t4_nreads", addr_log.size(), 2);
    if (addr_log.size() >= 2) begin
      chk("t4_addr0", addr_log[0], 32'hFFFF_FFFF);
      chk("t4_addr1", addr_log[1], 32'h0000_0000);
    end

    // Timeout on third word with two words buffered: flush and error.
    out_ready = 1'b0;
    hang_limit = reads_issued + 2;
    hang_en = 1'b1;
    send(32'h3000, 4, 1'b0);
    n = 0;
    while (!err_timeout && n < TMO + 200) begin
      tick(1);
      n++;
    end
    chk("t5_err", err_timeout, 1);
    chk("t5_latency_min", (n >= TMO), 1);
    chk("t5_stb", mem_stb_i, 0);
    chk("t5_flushed", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cmd_ready", cmd_ready, 1);
    hang_en = 1'b0;
    tick(3);
    out_ready = 1'b1;
    send(32'h4000, 1, 1'b1);
    chk("t5_err_cleared", err_timeout, 0);
    wait_done(200, "t5_done");

    // Reset while waiting with three words queued.
    out_ready = 1'b0; cmp_dly = 6;
    r0 = reads_issued;
    send(32'h5000, 6, 1'b1);
    n = 0;
    while (reads_issued - r0 < 4 && n < 300) begin
      tick(1);
      n++;
    end
    chk("t6_reached_4th", reads_issued - r0, 4);
    tick(2);
    chk("t6_pre_out_valid", out_valid, 1);
    chk("t6_pre_busy", busy, 1);
    rst_i = 1'b1;
    tick(1);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_stb", mem_stb_i, 0);
    rst_i = 1'b0;
    sb.delete();
    tick(12);
    out_ready = 1'b1; cmp_dly = 2;
    send(32'h6000, 3, 1'b1);
    wait_done(200, "t6_recover_done");

    chk("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
